// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS controller.
//   - state_t  : sequencer phases
//   - iclass_t : decoded instruction class that steers the sequencing
//   - opcode / funct constants, alu_c / result_c / pc_next_c encodings
//   - ctrl_t   : packed control word produced by mc_decoder
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // CL_NONE sits at zero so the all-zero reset control word is a legal value.
    typedef enum logic [3:0] {
        CL_NONE,
        CL_ALU,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_BNE,
        CL_J,
        CL_HALT,
        CL_ILL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    localparam logic [1:0] RES_ALU   = 2'd0;
    localparam logic [1:0] RES_MEM   = 2'd1;
    localparam logic [1:0] RES_SHIFT = 2'd2;

    localparam logic [1:0] PCN_SEQ = 2'd0;
    localparam logic [1:0] PCN_BR  = 2'd1;
    localparam logic [1:0] PCN_JMP = 2'd2;

    typedef struct packed {
        iclass_t    cls;
        logic [3:0] alu_c;
        logic [1:0] result_c;
        logic       argB_c;
        logic       dest_reg_c;
        logic       ext_c;
        logic       sh_d_c;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '0;

endpackage

// File: rtl/mc_decoder.sv
// mc_decoder: purely combinational instruction decoder.
// Ports:
//   i_op_c    [5:0] opcode field instr[31:26]
//   i_funct   [5:0] function field instr[5:0]
//   o_ctrl    ctrl_t class plus datapath selects
//   o_illegal 1     opcode/funct not decodable
module mc_decoder
    import mc_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'h3F
) (
    input  logic [5:0] i_op_c,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl     = CTRL_RESET;
        o_ctrl.cls = CL_ILL;
        // HALT_OP is checked first so it wins even if it aliases a real opcode.
        if (i_op_c == HALT_OP) begin
            o_ctrl.cls = CL_HALT;
        end else begin
            case (i_op_c)
                OP_RTYPE: begin
                    o_ctrl.cls = CL_ALU;
                    case (i_funct)
                        FN_ADD: o_ctrl.alu_c = ALU_ADD;
                        FN_SUB: o_ctrl.alu_c = ALU_SUB;
                        FN_AND: o_ctrl.alu_c = ALU_AND;
                        FN_OR:  o_ctrl.alu_c = ALU_OR;
                        FN_SLT: o_ctrl.alu_c = ALU_SLT;
                        FN_SLL: begin
                            o_ctrl.result_c = RES_SHIFT;
                            o_ctrl.sh_d_c   = 1'b0;
                        end
                        FN_SRL: begin
                            o_ctrl.result_c = RES_SHIFT;
                            o_ctrl.sh_d_c   = 1'b1;
                        end
                        default: o_ctrl.cls = CL_ILL;
                    endcase
                end
                OP_J: o_ctrl.cls = CL_J;
                OP_BEQ: begin
                    o_ctrl.cls   = CL_BEQ;
                    o_ctrl.alu_c = ALU_SUB;
                    o_ctrl.ext_c = 1'b1;
                end
                OP_BNE: begin
                    o_ctrl.cls   = CL_BNE;
                    o_ctrl.alu_c = ALU_SUB;
                    o_ctrl.ext_c = 1'b1;
                end
                OP_ADDI: begin
                    o_ctrl.cls        = CL_ALU;
                    o_ctrl.alu_c      = ALU_ADD;
                    o_ctrl.ext_c      = 1'b1;
                    o_ctrl.argB_c     = 1'b1;
                    o_ctrl.dest_reg_c = 1'b1;
                end
                OP_ANDI: begin
                    o_ctrl.cls        = CL_ALU;
                    o_ctrl.alu_c      = ALU_AND;
                    o_ctrl.argB_c     = 1'b1;
                    o_ctrl.dest_reg_c = 1'b1;
                end
                OP_ORI: begin
                    o_ctrl.cls        = CL_ALU;
                    o_ctrl.alu_c      = ALU_OR;
                    o_ctrl.argB_c     = 1'b1;
                    o_ctrl.dest_reg_c = 1'b1;
                end
                OP_LW: begin
                    o_ctrl.cls        = CL_LW;
                    o_ctrl.alu_c      = ALU_ADD;
                    o_ctrl.ext_c      = 1'b1;
                    o_ctrl.argB_c     = 1'b1;
                    o_ctrl.dest_reg_c = 1'b1;
                    o_ctrl.result_c   = RES_MEM;
                end
                OP_SW: begin
                    o_ctrl.cls    = CL_SW;
                    o_ctrl.alu_c  = ALU_ADD;
                    o_ctrl.ext_c  = 1'b1;
                    o_ctrl.argB_c = 1'b1;
                end
                default: o_ctrl.cls = CL_ILL;
            endcase
        end
        o_illegal = (o_ctrl.cls == CL_ILL);
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle sequencer for the MIPS datapath.
// Phases FETCH -> DECODE -> (EXEC -> (MEM | WB)) -> FETCH, plus HALT.
// Ports:
//   clk, reset (async, active low)
//   op_c, funct           instruction fields from the IR
//   zero                  ALU zero flag (branch resolution in EXEC)
//   imem_ready, mem_ready memory handshakes
//   imem_req, ir_we, pc_en, mem_re, mem_we, we_c   strobes (combinational)
//   argB_c, dest_reg_c, ext_c, sh_d_c, alu_c, result_c  selects registered in DECODE
//   pc_next_c             PC source, valid when pc_en = 1
//   halted, illegal       status
module mc_controller
    import mc_pkg::*;
#(
    parameter logic [5:0] HALT_OP      = 6'h3F,
    parameter bit         ILLEGAL_SKIP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_c,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       mem_ready,
    output logic       imem_req,
    output logic       ir_we,
    output logic       pc_en,
    output logic       mem_re,
    output logic       mem_we,
    output logic       we_c,
    output logic       argB_c,
    output logic       dest_reg_c,
    output logic       ext_c,
    output logic       sh_d_c,
    output logic [1:0] pc_next_c,
    output logic [1:0] result_c,
    output logic [3:0] alu_c,
    output logic       halted,
    output logic       illegal
);

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    ctrl_t  w_dec_ctrl;
    logic   w_dec_illegal;

    mc_decoder #(
        .HALT_OP (HALT_OP)
    ) u_decoder (
        .i_op_c    (op_c),
        .i_funct   (funct),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= CTRL_RESET;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_ctrl <= w_dec_ctrl;
            end
        end
    end

    assign argB_c     = r_ctrl.argB_c;
    assign dest_reg_c = r_ctrl.dest_reg_c;
    assign ext_c      = r_ctrl.ext_c;
    assign sh_d_c     = r_ctrl.sh_d_c;
    assign result_c   = r_ctrl.result_c;
    assign alu_c      = r_ctrl.alu_c;

    always_comb begin
        w_next    = r_state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_en     = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        we_c      = 1'b0;
        pc_next_c = PCN_SEQ;
        halted    = 1'b0;
        illegal   = 1'b0;

        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // j and illegal-skip retire here from the live decode,
                // before the control word is registered.
                case (w_dec_ctrl.cls)
                    CL_J: begin
                        pc_en     = 1'b1;
                        pc_next_c = PCN_JMP;
                        w_next    = S_FETCH;
                    end
                    CL_HALT: w_next = S_HALT;
                    CL_ILL: begin
                        illegal = w_dec_illegal;
                        if (ILLEGAL_SKIP) begin
                            pc_en  = 1'b1;
                            w_next = S_FETCH;
                        end else begin
                            w_next = S_HALT;
                        end
                    end
                    default: w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (r_ctrl.cls)
                    CL_BEQ, CL_BNE: begin
                        pc_en = 1'b1;
                        if (zero ^ (r_ctrl.cls == CL_BNE)) begin
                            pc_next_c = PCN_BR;
                        end
                        w_next = S_FETCH;
                    end
                    CL_LW, CL_SW: w_next = S_MEM;
                    default:      w_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (r_ctrl.cls == CL_LW) begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        we_c   = 1'b1;
                        pc_en  = 1'b1;
                        w_next = S_FETCH;
                    end
                end else if (r_ctrl.cls == CL_SW) begin
                    mem_we = 1'b1;
                    if (mem_ready) begin
                        pc_en  = 1'b1;
                        w_next = S_FETCH;
                    end
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_WB: begin
                we_c   = 1'b1;
                pc_en  = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset assertion kills every strobe at once, independent of the clock.
        if (!reset) begin
            imem_req  = 1'b0;
            ir_we     = 1'b0;
            pc_en     = 1'b0;
            mem_re    = 1'b0;
            mem_we    = 1'b0;
            we_c      = 1'b0;
            pc_next_c = PCN_SEQ;
            halted    = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle sequencer for the MIPS datapath.
- Fetches each instruction through a request/ready instruction-memory handshake and decodes op_c/funct.
- Drives the datapath mux/ALU selects, plus the pc_en, ir_we, register-write and data-memory strobes, one phase per cycle.
- Handles variable memory wait states, illegal opcodes and a HALT instruction.

Parameters:
- HALT_OP, 6'h3F, opcode that stops sequencing.
- ILLEGAL_SKIP, 1, 1 = illegal instruction is skipped (PC+4); 0 = illegal instruction enters HALT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_c  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction word valid this cycle.
- mem_ready  in  1  data memory access complete this cycle.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  load the instruction register.
- pc_en  out  1  load the PC from the pc_next mux.
- mem_re  out  1  data read request.
- mem_we  out  1  data write request.
- we_c  out  1  register file write enable.
- argB_c  out  1  0 = rd2, 1 = immediate.
- dest_reg_c  out  1  0 = rd, 1 = rt.
- ext_c  out  1  1 = sign-extend, 0 = zero-extend.
- sh_d_c  out  1  0 = left shift, 1 = right shift.
- pc_next_c  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
- result_c  out  2  0 = ALU, 1 = memory, 2 = shifter.
- alu_c  out  4  0 = ADD, 1 = SUB, 2 = AND, 3 = OR, 4 = SLT.
- halted  out  1  controller is in HALT.
- illegal  out  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset: state = FETCH; every output and every registered select = 0. Assertion is asynchronous and forces all strobes low immediately, so there is never a partial write. After release, the first cycle is FETCH with imem_req = 1.
- FETCH: imem_req = 1 until imem_ready. In the cycle imem_ready = 1: ir_we = 1, next state DECODE. Otherwise stay in FETCH.
- DECODE: op_c/funct are decoded and the select outputs are registered at the end of this cycle. The selects then stay stable until the next DECODE.
  - j (op 02): pc_en = 1, pc_next_c = 2, next state FETCH.
  - HALT_OP: next state HALT.
  - Illegal: illegal = 1. If ILLEGAL_SKIP, pc_en = 1 and pc_next_c = 0, next state FETCH; else next state HALT.
  - Any other legal instruction: next state EXEC.
- EXEC:
  - beq (04) / bne (05): alu_c = SUB. pc_en = 1, with pc_next_c = 1 if (zero XOR bne) else 0. Next state FETCH.
  - lw (23) / sw (2B): next state MEM.
  - All others: next state WB.
- MEM:
  - lw holds mem_re = 1 until mem_ready. In the ready cycle: we_c = 1, result_c = 1, pc_en = 1, next state FETCH.
  - sw holds mem_we = 1 until mem_ready. In the ready cycle: pc_en = 1, next state FETCH.
  - we_c is never asserted for sw.
- WB: we_c = 1, pc_en = 1, pc_next_c = 0, next state FETCH.
- Decode table:
  - R-type (op 00), funct 20 = ADD, 22 = SUB, 24 = AND, 25 = OR, 2A = SLT: dest_reg_c = 0, argB_c = 0, result_c = 0.
  - funct 00 = sll, 02 = srl: result_c = 2, sh_d_c = 0 or 1 respectively.
  - addi (08): ADD, sign-extend. andi (0C): AND, zero-extend. ori (0D): OR, zero-extend. All three use argB_c = 1, dest_reg_c = 1.
  - lw/sw: ADD, sign-extend, argB_c = 1.
  - Any other op or R-type funct is illegal.
- Cycle counts with zero memory wait states: R/I ALU = 4, lw = 4, sw = 4, branch = 3, j = 2. Each wait cycle adds 1.
- Strobes: imem_req, ir_we, pc_en, we_c, mem_re, mem_we and illegal are combinational from state, decoded class and the ready inputs. Exactly one pc_en pulse per retired instruction.
- Simultaneous events:
  - mem_ready or imem_ready outside the matching state is ignored.
  - Ready asserted in the first cycle of MEM or FETCH completes the access in that cycle.
- HALT: all strobes 0, halted = 1. Leaves HALT only on reset.

Decomposition:
- Shared package mc_pkg:
  - state enum;
  - opcode and funct constants;
  - alu_c, result_c and pc_next_c encodings;
  - a packed control-word struct.
- One sub-module, mc_decoder: purely combinational op_c/funct → control word plus illegal flag. mc_controller instantiates it and registers its output in DECODE.

Test Plan:
- Reset low mid-MEM of sw with mem_we = 1 → mem_we drops in the same cycle. After release: state FETCH, imem_req = 1, all other outputs 0.
- add (op 00, funct 20), zero wait states → ir_we at cycle 1. WB at cycle 4 with we_c = 1, result_c = 0, alu_c = 0, pc_en = 1. Exactly one we_c pulse.
- lw with mem_ready delayed 3 cycles → mem_re high for 4 cycles. we_c, result_c = 1 and pc_en all coincide with mem_ready. Instruction totals 7 cycles.
- beq: zero = 1 → pc_next_c = 1. beq: zero = 0 → pc_next_c = 0. bne: zero = 0 → pc_next_c = 1. Each case asserts pc_en in EXEC with we_c = 0 and finishes in 3 cycles.
- op 3E with ILLEGAL_SKIP = 1 → illegal pulses 1 cycle in DECODE, pc_en = 1 with pc_next_c = 0, no we_c.
- HALT_OP → halted = 1 from the cycle after DECODE. imem_req stays 0 for 20 cycles until reset.
